// File: rtl/sub_bytes_seq.sv
// sub_bytes_seq: byte-serial SubBytes/ShiftRows sequencer around an external pipelined sbox
module sub_bytes_seq #(
  parameter int SBOX_LATENCY = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         decrypt_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic [7:0]   sbox_data_o,
  output logic         sbox_decrypt_o,
  input  logic [7:0]   sbox_data_i
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FEED = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE = 2'd3;
  logic [1:0] state;
  logic [3:0] idx;
  logic [127:0] st;
  logic dec;
  logic [SBOX_LATENCY-1:0] pv;
  logic [3:0] pi [SBOX_LATENCY];
  logic [3:0] src, dst;
  logic [1:0] r, c;
  assign src = pi[SBOX_LATENCY-1];
  assign r = src[1:0];
  assign c = src[3:2];
  assign dst = {dec ? c + r : c - r, r};
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign sbox_data_o = state == FEED ? st[{~idx, 3'b000} +: 8] : 8'h00;
  assign sbox_decrypt_o = dec;
  always_ff @(posedge clk) begin
    pi[0] <= idx;
    for (int i = 1; i < SBOX_LATENCY; i++) pi[i] <= pi[i-1];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      st <= '0;
      dec <= 1'b0;
      pv <= '0;
      data_out <= '0;
    end else begin
      pv <= SBOX_LATENCY'({pv, state == FEED});
      if (pv[SBOX_LATENCY-1]) data_out[{~dst, 3'b000} +: 8] <= sbox_data_i;
      case (state)
        IDLE: if (in_valid) begin
          st <= data_in;
          dec <= decrypt_in;
          idx <= '0;
          state <= FEED;
        end
        FEED: begin
          idx <= idx + 4'd1;
          if (idx == 4'd15) state <= DRAIN;
        end
        DRAIN: begin
          idx <= idx + 4'd1;
          if (idx == 4'(SBOX_LATENCY - 1)) state <= DONE;
        end
        default: if (out_ready) state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sub_bytes_seq.sv
// tb_sub_bytes_seq: scoreboard bench for sub_bytes_seq with a behavioural one-stage AES sbox
module tb_sub_bytes_seq;
  logic clk = 0, reset = 1, in_valid = 0, decrypt_in = 0, out_ready = 1;
  logic [127:0] data_in = '0;
  logic in_ready, out_valid, sbox_decrypt_o;
  logic [127:0] data_out;
  logic [7:0] sbox_data_o, sbox_data_i;
  logic [7:0] sreg = 8'h00;
  logic [7:0] sb [256];
  logic [7:0] isb [256];
  logic [127:0] q [$];
  int n_cmp = 0, n_bad = 0, cyc = 0;
  localparam logic [127:0] MIX_IN = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] MIX_OUT = 128'h636b6776f201ab7b30d777c5fe7c6f2b;

  sub_bytes_seq #(.SBOX_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .decrypt_in(decrypt_in), .out_valid(out_valid),
    .out_ready(out_ready), .data_out(data_out), .sbox_data_o(sbox_data_o),
    .sbox_decrypt_o(sbox_decrypt_o), .sbox_data_i(sbox_data_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) sreg <= sbox_data_o;
  assign sbox_data_i = sbox_decrypt_o ? isb[sreg] : sb[sreg];

  always @(negedge clk) if (!reset && out_valid && out_ready) begin
    n_cmp++;
    if (q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty data_out=%h required=no result", data_out);
    end else begin
      logic [127:0] e;
      e = q.pop_front();
      if (data_out !== e) begin
        n_bad++;
        $display("FAIL scoreboard data_out=%h required=%h", data_out, e);
      end
    end
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_tables();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 0, s;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sb[x] = s;
      isb[s] = 8'(x);
    end
  endtask

  // Row-shift form: output (r,c) takes input (r,c+r) on encrypt, (r,c-r) on decrypt.
  function automatic logic [127:0] model(input logic [127:0] d, input logic dc);
    logic [127:0] o = '0;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < 4; cc++) begin
        int sc = dc ? ((cc - rr + 4) % 4) : ((cc + rr) % 4);
        logic [7:0] b = d[127 - 8 * (4 * sc + rr) -: 8];
        o[127 - 8 * (4 * cc + rr) -: 8] = dc ? isb[b] : sb[b];
      end
    return o;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic send(input logic [127:0] d, input logic dc, input logic push,
                      input logic [127:0] e, output int acc);
    int t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (!in_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout in_ready=%b required=1", in_ready);
    end
    in_valid = 1; data_in = d; decrypt_in = dc;
    if (push) q.push_back(e);
    @(posedge clk); #1;
    acc = cyc;
    in_valid = 0;
  endtask

  task automatic wait_valid(output int k);
    k = 0;
    forever begin
      @(negedge clk);
      if (out_valid || k >= 60) break;
      @(posedge clk); #1; k++;
    end
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp += 5;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    if (data_out !== '0) begin n_bad++; $display("FAIL reset_data_out got=%h required=0", data_out); end
    if (sbox_data_o !== 8'h00) begin n_bad++; $display("FAIL reset_sbox_data got=%h required=00", sbox_data_o); end
    if (sbox_decrypt_o !== 1'b0) begin n_bad++; $display("FAIL reset_sbox_dec got=%b required=0", sbox_decrypt_o); end
    @(posedge clk); #1;
    reset = 0;
  endtask

  task automatic test_uniform();
    int a, k;
    out_ready = 1;
    send('0, 0, 1, {16{8'h63}}, a);
    wait_valid(k);
    n_cmp++;
    if (k !== 17) begin n_bad++; $display("FAIL uniform_latency got=%0d required=17", k); end
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL uniform_pulse_width out_valid=%b required=0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_mixed();
    int a, k;
    send(MIX_IN, 0, 1, MIX_OUT, a);
    for (int i = 0; i < 16; i++) begin
      logic [7:0] eb = 8'(i);
      @(negedge clk);
      n_cmp += 2;
      if (sbox_data_o !== eb) begin n_bad++; $display("FAIL mixed_feed_byte%0d got=%h required=%h", i, sbox_data_o, eb); end
      if (sbox_decrypt_o !== 1'b0) begin n_bad++; $display("FAIL mixed_sbox_dec%0d got=%b required=0", i, sbox_decrypt_o); end
      @(posedge clk); #1;
    end
    wait_valid(k);
    @(posedge clk); #1;
  endtask

  task automatic test_decrypt();
    int a, k;
    send(MIX_OUT, 1, 1, MIX_IN, a);
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      n_cmp++;
      if (sbox_decrypt_o !== 1'b1) begin n_bad++; $display("FAIL decrypt_sbox_dec%0d got=%b required=1", i, sbox_decrypt_o); end
      @(posedge clk); #1;
    end
    wait_valid(k);
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    int a, k;
    logic [127:0] d = rnd128(), held;
    out_ready = 0;
    send(d, 0, 1, model(d, 0), a);
    wait_valid(k);
    held = data_out;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; data_in = ~d;
      @(negedge clk);
      n_cmp += 3;
      if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid%0d got=%b required=1", i, out_valid); end
      if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready%0d got=%b required=0", i, in_ready); end
      if (data_out !== held) begin n_bad++; $display("FAIL bp_data_hold%0d got=%h required=%h", i, data_out, held); end
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp += 2;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_idle got=%b required=1", in_ready); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release_valid got=%b required=0", out_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int a, k;
    send(MIX_IN, 0, 0, '0, a);
    repeat (8) begin @(posedge clk); #1; end
    @(negedge clk);
    n_cmp++;
    if (sbox_data_o !== 8'h08) begin n_bad++; $display("FAIL rmid_issue8 got=%h required=08", sbox_data_o); end
    #1 reset = 1;
    #1;
    n_cmp += 5;
    if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rmid_in_ready got=%b required=1", in_ready); end
    if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_out_valid got=%b required=0", out_valid); end
    if (data_out !== '0) begin n_bad++; $display("FAIL rmid_data_out got=%h required=0", data_out); end
    if (sbox_data_o !== 8'h00) begin n_bad++; $display("FAIL rmid_sbox_data got=%h required=00", sbox_data_o); end
    if (sbox_decrypt_o !== 1'b0) begin n_bad++; $display("FAIL rmid_sbox_dec got=%b required=0", sbox_decrypt_o); end
    @(posedge clk); #1;
    reset = 0;
    @(posedge clk); #1;
    @(negedge clk);
    n_cmp++;
    if (data_out !== '0) begin n_bad++; $display("FAIL rmid_stale_write got=%h required=0", data_out); end
    @(posedge clk); #1;
    send(MIX_IN, 0, 1, MIX_OUT, a);
    wait_valid(k);
    n_cmp++;
    if (k !== 17) begin n_bad++; $display("FAIL rmid_latency got=%0d required=17", k); end
    @(posedge clk); #1;
  endtask

  task automatic test_churn(input logic dc);
    int a, k;
    logic [127:0] d = rnd128();
    send(d, dc, 1, model(d, dc), a);
    for (int i = 0; i < 17; i++) begin
      data_in = rnd128(); decrypt_in = i[0] ^ ~dc;
      @(negedge clk);
      n_cmp++;
      if (sbox_decrypt_o !== dc) begin n_bad++; $display("FAIL churn_sbox_dec%0d got=%b required=%b", i, sbox_decrypt_o, dc); end
      if (i < 16) begin
        logic [7:0] eb = d[127 - 8 * i -: 8];
        n_cmp++;
        if (sbox_data_o !== eb) begin n_bad++; $display("FAIL churn_feed_byte%0d got=%h required=%h", i, sbox_data_o, eb); end
      end
      @(posedge clk); #1;
    end
    decrypt_in = 0;
    wait_valid(k);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int acc [3];
    int k;
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      logic [127:0] d = rnd128();
      logic dc = 1'($urandom_range(0, 1));
      send(d, dc, 1, model(d, dc), acc[i]);
    end
    n_cmp += 2;
    if (acc[1] - acc[0] !== 19) begin n_bad++; $display("FAIL b2b_period0 got=%0d required=19", acc[1] - acc[0]); end
    if (acc[2] - acc[1] !== 19) begin n_bad++; $display("FAIL b2b_period1 got=%0d required=19", acc[2] - acc[1]); end
    wait_valid(k);
    @(posedge clk); #1;
  endtask

  initial begin
    build_tables();
    test_reset();
    test_uniform();
    test_mixed();
    test_decrypt();
    test_backpressure();
    test_reset_mid();
    test_churn(0);
    test_churn(1);
    test_back_to_back();
    repeat (3) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin n_bad++; $display("FAIL scoreboard_leftover got=%0d required=0", q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
